// File: rtl/fpdcvt.sv
// fpdcvt - sequential decoder for the 8-bit sign/exponent/significand format.
//
// Turns in_data = {S, E[2:0], F[3:0]} into the 12-bit two's-complement value
// (-1)^S * F * 2^E. It shifts the significand left one bit per cycle for E
// cycles, then optionally negates. The result is held in out_data until the
// consumer takes it.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_data   encoded input byte, sampled only on the accept edge
//   in_valid  producer has a byte for us
//   in_ready  decoder is idle and out of reset
//   out_data  decoded result, updated only on entry to DONE
//   out_valid out_data holds a finished result
//   out_ready consumer accepts out_data
//   busy      conversion in progress or result pending
module fpdcvt (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, NEG, DONE} state_t;

  state_t             state, state_nxt;
  logic signed [11:0] acc, acc_nxt;
  logic        [2:0]  cnt, cnt_nxt;
  logic               sign, sign_nxt;
  logic signed [11:0] res;
  logic               accept;

  // Two's-complement negation wraps modulo 2^12; the magnitude never exceeds
  // 1920, so the wrap cannot lose information.
  function automatic logic signed [11:0] negate(input logic signed [11:0] v);
    return -v;
  endfunction

  // in_ready is gated by rst so that it reads low for the whole reset period,
  // even though the state register already sits in IDLE.
  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = res;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    sign_nxt  = sign;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt  = {8'b0, in_data[3:0]};
          cnt_nxt  = in_data[6:4];
          sign_nxt = in_data[7];
          if (in_data[6:4] != 3'd0) state_nxt = SHIFT;
          else if (in_data[7])      state_nxt = NEG;
          else                      state_nxt = DONE;
        end
      end
      SHIFT: begin
        acc_nxt = acc <<< 1;
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) state_nxt = sign ? NEG : DONE;
      end
      NEG: begin
        acc_nxt   = negate(acc);
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      sign  <= sign_nxt;
      // Capture the value being formed on the edge that enters DONE, so the
      // output register is loaded exactly once per conversion.
      if (state_nxt == DONE && state != DONE) res <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_fpdcvt.sv
// tb_fpdcvt - self-checking bench for fpdcvt.
// Expected values come from an arithmetic model of (-1)^S * F * 2^E and the
// latency rule 1+E+S, plus constant tables for the directed vectors.
module tb_fpdcvt;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int tests;
  int fails;

  fpdcvt dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ref_val(input logic [7:0] b);
    int f, e, v;
    f = int'(b[3:0]);
    e = int'(b[6:4]);
    v = f * (2 ** e);
    if (b[7]) v = -v;
    return v[11:0];
  endfunction

  function automatic int ref_lat(input logic [7:0] b);
    return 1 + int'(b[6:4]) + int'(b[7]);
  endfunction

  // Drives one byte and waits for out_valid. Called and returns at a negedge.
  // Toggles in_data randomly while the conversion runs.
  task automatic convert(input logic [7:0] b, output int lat,
                         output logic [11:0] r, output bit to);
    int w;
    to  = 1'b0;
    lat = 0;
    r   = '0;
    w   = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      to = 1'b1;
      return;
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      in_data = 8'($urandom);
      lat++;
    end
    if (!out_valid) to = 1'b1;
    r = out_data;
  endtask

  task automatic test_reset;
    #3;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (out_data !== 12'h000) begin fails++; $display("FAIL reset_out_data got=%h exp=000", out_data); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [7:0]  vin [8] = '{8'h00, 8'h80, 8'h2E, 8'h5D, 8'h7F, 8'hAA, 8'hDD, 8'hFF};
    logic [11:0] vexp[8] = '{12'h000, 12'h000, 12'h038, 12'h1A0, 12'h780, 12'hFD8, 12'hE60, 12'h880};
    int          vlat[8] = '{1, 2, 3, 6, 8, 4, 7, 9};
    int lat;
    logic [11:0] r;
    bit to;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      convert(vin[i], lat, r, to);
      tests++; if (to) begin fails++; $display("FAIL dir_timeout in=%h", vin[i]); end
      tests++; if (r !== vexp[i]) begin fails++; $display("FAIL dir_data in=%h got=%h exp=%h", vin[i], r, vexp[i]); end
      tests++; if (lat != vlat[i]) begin fails++; $display("FAIL dir_latency in=%h got=%0d exp=%0d", vin[i], lat, vlat[i]); end
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dir_one_cycle_valid in=%h got=%b exp=0", vin[i], out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL dir_ready_after in=%h got=%b exp=1", vin[i], in_ready); end
    end
  endtask

  task automatic test_random;
    int lat;
    logic [11:0] r;
    bit to;
    logic [7:0] b;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      convert(b, lat, r, to);
      tests++; if (to) begin fails++; $display("FAIL rnd_timeout in=%h", b); end
      tests++; if (r !== ref_val(b)) begin fails++; $display("FAIL rnd_data in=%h got=%h exp=%h", b, r, ref_val(b)); end
      tests++; if (lat != ref_lat(b)) begin fails++; $display("FAIL rnd_latency in=%h got=%0d exp=%0d", b, lat, ref_lat(b)); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat;
    logic [11:0] r;
    bit to;
    out_ready = 1'b0;
    convert(8'h2E, lat, r, to);
    tests++; if (to) begin fails++; $display("FAIL bp_timeout"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); end
      tests++; if (out_data !== 12'h038) begin fails++; $display("FAIL bp_data cyc=%0d got=%h exp=038", i, out_data); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_busy cyc=%0d got=%b exp=1", i, busy); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tests++; if (out_data !== 12'h038) begin fails++; $display("FAIL bp_hold_data got=%h exp=038", out_data); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q[$];
    logic [7:0] b;
    int accepts, handshakes, w;
    accepts    = 0;
    handshakes = 0;
    in_valid   = 1'b1;
    for (int c = 0; c < 300; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      if (in_ready) begin
        q.push_back(in_data);
        accepts++;
      end
      if (out_valid && out_ready) begin
        handshakes++;
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL b2b_extra_result got=%h", out_data);
        end else begin
          b = q.pop_front();
          if (out_data !== ref_val(b)) begin fails++; $display("FAIL b2b_data in=%h got=%h exp=%h", b, out_data, ref_val(b)); end
        end
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (busy && w < 20) begin
      if (out_valid) begin
        handshakes++;
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL b2b_extra_result got=%h", out_data);
        end else begin
          b = q.pop_front();
          if (out_data !== ref_val(b)) begin fails++; $display("FAIL b2b_data in=%h got=%h exp=%h", b, out_data, ref_val(b)); end
        end
      end
      @(negedge clk);
      w++;
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_drain_timeout busy=%b exp=0", busy); end
    tests++; if (handshakes != accepts) begin fails++; $display("FAIL b2b_count got=%0d exp=%0d", handshakes, accepts); end
    tests++; if (accepts < 20) begin fails++; $display("FAIL b2b_accepts got=%0d exp>=20", accepts); end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [11:0] r;
    bit to;
    bit seen;
    out_ready = 1'b1;
    convert(8'h5D, lat, r, to);
    @(negedge clk);
    // Accept 7F and assert rst mid-cycle in the 4th SHIFT cycle.
    in_data  = 8'h7F;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rm_busy_before got=%b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy got=%b exp=0", busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rm_in_ready got=%b exp=0", in_ready); end
    tests++; if (out_data !== 12'h000) begin fails++; $display("FAIL rm_out_data got=%h exp=000", out_data); end
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1 if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rm_no_valid got=%b exp=0", seen); end
    convert(8'h12, lat, r, to);
    tests++; if (to) begin fails++; $display("FAIL rm_after_timeout"); end
    tests++; if (r !== 12'h004) begin fails++; $display("FAIL rm_after_data got=%h exp=004", r); end
    tests++; if (lat != 2) begin fails++; $display("FAIL rm_after_latency got=%0d exp=2", lat); end
    @(negedge clk);
  endtask

  task automatic test_reset_done;
    int lat;
    logic [11:0] r;
    bit to;
    out_ready = 1'b0;
    convert(8'hAA, lat, r, to);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rd_valid_before got=%b exp=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rd_valid got=%b exp=0", out_valid); end
    tests++; if (out_data !== 12'h000) begin fails++; $display("FAIL rd_data got=%h exp=000", out_data); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rd_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_reset_done;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
